// File: rtl/recur_accum.sv
// recur_accum: y[n] = (y[n-1] << SHIFT) + x[n] over a run of programmable length,
// with wrap/saturate overflow handling and start/busy/done sequencing.
module recur_accum #(
  parameter int W     = 32,
  parameter int CNT_W = 7,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             mode,
  input  logic [W-1:0]     x,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [W-1:0]     y,
  output logic             y_valid,
  output logic             busy,
  output logic             done,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, len_q;
  logic             mode_q, y_valid_q, ovf_q;
  logic [W-1:0]     y_q, y_d;
  logic [W+SHIFT:0] acc_full;
  logic             acc_ovf;
  // Bits shifted out of y land above W, so they take part in overflow detection.
  always_comb begin
    acc_full = (cnt_q == '0) ? {{(SHIFT+1){1'b0}}, x}
                             : ({{(SHIFT+1){1'b0}}, y_q} << SHIFT) + {{(SHIFT+1){1'b0}}, x};
    acc_ovf  = |acc_full[W+SHIFT:W];
    y_d      = (acc_ovf && mode_q) ? '1 : acc_full[W-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          len_q   <= len;
          mode_q  <= mode;
          state_q <= (len != '0) ? RUN : DONE;
        end
        RUN: if (x_valid) begin
          y_q       <= y_d;
          y_valid_q <= 1'b1;
          ovf_q     <= ovf_q | acc_ovf;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == len_q - CNT_W'(1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign x_ready = (state_q == RUN);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_recur_accum.sv
// tb_recur_accum: randomized and directed runs against an arithmetic reference model,
// with expected outputs queued by the driver and checked by an independent monitor.
module tb_recur_accum;
  localparam int W = 8, CNT_W = 7, SHIFT = 1;
  logic clk = 0, rst = 0, start = 0, mode = 0, x_valid = 0;
  logic [CNT_W-1:0] len = '0;
  logic [W-1:0] x = '0, y;
  logic x_ready, y_valid, busy, done, ovf;
  typedef struct {logic [W-1:0] y; bit done; bit ovf; bit has_y;} exp_t;
  exp_t q[$];
  int xs[$];
  int y_m = 0;
  int checks = 0, errors = 0;

  recur_accum #(.W(W), .CNT_W(CNT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .x(x),
    .x_valid(x_valid), .x_ready(x_ready), .y(y), .y_valid(y_valid),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (y_valid || done)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: y_valid=%b done=%b y=%0d at %0t", y_valid, done, y, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (y_valid !== e.has_y || y !== e.y || done !== e.done || ovf !== e.ovf || busy !== !e.done) begin
          errors++;
          $display("FAIL output: got y_valid=%b y=%0d done=%b ovf=%b busy=%b expected y_valid=%b y=%0d done=%b ovf=%b busy=%b at %0t",
                   y_valid, y, done, ovf, busy, e.has_y, e.y, e.done, e.ovf, !e.done, $time);
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_y_valid"}, y_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_x_ready"}, x_ready, 0);
  endtask

  // bub < 0 means random bubbles; abort_at > 0 resets after that many samples.
  task automatic run(input int n, input bit m, input int bub, input bit noise, input int abort_at);
    longint acc;
    bit ovf_m;
    int v;
    @(posedge clk); #1;
    start = 1; len = CNT_W'(n); mode = m; x_valid = 0;
    @(posedge clk); #1;
    start = noise && ($urandom_range(0, 1) == 1);
    len = CNT_W'($urandom); mode = 1'($urandom);
    chk("y_hold_after_start", y, y_m);
    chk("ovf_cleared_on_start", ovf, 0);
    ovf_m = 0;
    if (n == 0) q.push_back('{W'(y_m), 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < n; i++) begin
      repeat (bub < 0 ? $urandom_range(0, 3) : bub) begin
        x_valid = 0; x = W'($urandom);
        start = noise && ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
      end
      v = (xs.size() != 0) ? xs.pop_front() : int'($urandom_range(0, (1 << W) - 1));
      acc = (i == 0) ? longint'(v) : longint'(y_m) * (longint'(1) << SHIFT) + v;
      if (acc >= (longint'(1) << W)) ovf_m = 1;
      y_m = (ovf_m && acc >= (longint'(1) << W) && m) ? (1 << W) - 1 : int'(acc % (longint'(1) << W));
      q.push_back('{W'(y_m), i == n - 1, ovf_m, 1'b1});
      x_valid = 1; x = W'(v);
      start = noise && ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      x_valid = 0;
      if (i + 1 == abort_at) begin
        @(negedge clk); #2;
        rst = 0; #1;
        reset_checks("midrun_reset");
        y_m = 0;
        @(negedge clk); rst = 1;
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #12;
    reset_checks("reset");
    @(negedge clk); rst = 1;
    xs = '{1, 1, 1};        run(3, 0, 0, 0, 0);
    xs = '{200, 200};       run(2, 0, 0, 0, 0);
    xs = '{200, 200};       run(2, 1, 0, 0, 0);
    xs = '{1, 2, 3, 4};     run(4, 0, 2, 0, 0);
    run(0, 0, 0, 0, 0);
    xs = '{5};              run(1, 0, 0, 0, 0);
    run(10, 0, -1, 0, 4);
    xs = '{3, 3};           run(2, 0, 0, 0, 0);
    run(5, 1, -1, 1, 0);
    run(3, 0, -1, 1, 0);
    run((1 << CNT_W) - 1, 0, 0, 0, 0);
    run((1 << CNT_W) - 1, 1, -1, 1, 0);
    for (int r = 0; r < 25; r++)
      run(int'($urandom_range(0, 20)), 1'($urandom), -1, 1'($urandom), 0);
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("idle_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
